vga_linebuf_savemod: RTL and testbench
======================================

# vga_linebuf_savemod

Line-buffer stage directly upstream of the VGA timing/function module. It consumes that module's line-update tag and read-enable, fetches the requested display line from external frame memory into a ping-pong pair of line buffers, and streams pixels back on the 16-bit data input of the timing module. One buffer is filled from memory while the other is being displayed; the buffers swap on every line-update strobe.

## Interface
Parameters:
- XSIZE, 10'd320: words per line; also the depth of each line bank.
- YSIZE, 10'd240: lines per frame; iTag line numbers ≥ YSIZE are ignored.
- BASE_ADDR, 17'd0: frame-memory word address of line 0, pixel 0.

Ports:
- CLOCK  in  1  system/pixel clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- iTag  in  11  bit 10 = one-cycle line-update strobe; bits 9:0 = line number to fetch (held stable between strobes).
- iEn  in  1  read enable from the timing module; high for consecutive cycles across one line.
- oData  out  16  pixel word to the timing module.
- oReq  out  1  memory read request.
- oAddr  out  17  memory word address, valid while oReq = 1.
- iAck  in  1  memory acknowledge; iMData is valid in the same cycle.
- iMData  in  16  memory read data.
- oErr  out  1  sticky overrun flag. Present only with the macro; see Configuration.

## Operation
- Two banks, B0/B1, each XSIZE×16. The register `dsel` selects the display bank. The fill bank is ~dsel.
- FSM states:
  - IDLE: oReq = 0. A valid strobe (iTag[10] = 1 and iTag[9:0] < YSIZE) does all of the following, then goes to FILL:
    - toggles dsel;
    - loads `line = iTag[9:0]`;
    - clears the word counter `wc`;
    - clears the read pointer `rp`.
  - FILL: oReq = 1 and oAddr = BASE_ADDR + line*XSIZE + wc (17-bit, truncating).
    - On iAck = 1, write iMData to fill bank[wc] and increment wc.
    - If iAck = 1 while wc = XSIZE−1, return to IDLE; oReq drops on the next cycle.
- A strobe with line ≥ YSIZE is ignored entirely: no swap and no fill.
- Display side:
  - Each cycle that iEn = 1: oData ← display bank[rp], and rp increments, saturating at XSIZE−1.
  - Each cycle that iEn = 0: oData ← 0 and rp ← 0.
- Simultaneous strobe and final iAck in FILL: the final word is written, then the strobe is handled exactly as in IDLE (swap, new fill). This is not an overrun.
- Strobe in FILL before the final ack is an overrun, handled per Configuration.
- RESET while in FILL: the FSM returns to IDLE immediately, oReq = 0 on the next edge, and any in-flight iAck is ignored.

## Timing
- Reset values:
  - oData = 0, oReq = 0, oAddr = 0, oErr = 0.
  - dsel = 0, wc = 0, rp = 0, state IDLE.
  - Bank contents are not reset.
- Strobe sampled at edge t: at t+1, oReq = 1, oAddr = line address, and the swap is effective.
- Read latency is 1 cycle: iEn sampled high at edge t produces bank[rp] on oData after edge t. With iEn high for N consecutive cycles, oData carries words 0..N−1 on cycles t+1..t+N.
- Fill throughput is one word per cycle when iAck is held high. A full line (XSIZE = 320) takes 320 acked cycles, which fits within the 800-cycle line period.
- Line number n fetched on one line's strobe is displayed during the following line's iEn window.

## Configuration
- Macro: SAVEMOD_OVERRUN_EN.
- Defined:
  - A strobe during FILL, without a coincident final ack, aborts the fill and sets oErr = 1.
  - oErr stays set until RESET.
  - The strobe is then handled as in IDLE: swap, and restart with the new line and wc = 0.
- Undefined:
  - A strobe during FILL is ignored: no swap and no restart. The fill runs to completion.
  - The oErr port is tied to 0.

## Test plan
- Reset: hold RESET high for 3 cycles with iEn = 1. Required: oData = 0, oReq = 0, oAddr = 0, oErr = 0 throughout, and for 1 cycle after release.
- Single fill: strobe with line 5 and iAck always 1, BASE_ADDR = 0. Required:
  - oAddr runs 1600..1919 on 320 consecutive cycles;
  - oReq drops the cycle after the ack at address 1919.
- Display: after the fill of line 5 with memory word = address, strobe line 6, then drive iEn high for 320 cycles. Required: oData = 1600..1919 on the 320 cycles starting one cycle after iEn rises, and 0 after iEn falls.
- Throttled ack: iAck high every 2nd cycle for line 0. Required: 320 writes complete within 640 cycles, and every oAddr holds steady until acked.
- Overrun with SAVEMOD_OVERRUN_EN defined: strobe line 3, ack 100 words, then strobe line 4. Required:
  - oErr = 1 from the next cycle;
  - oAddr restarts at 1280;
  - dsel has toggled twice.
- Boundary: strobe with line 240. Required: oReq stays 0 and dsel is unchanged. Also strobe coincident with the final ack: no oErr, and the new fill starts on the next cycle.

Source files
------------

// File: rtl/vga_linebuf_savemod.sv
// vga_linebuf_savemod: ping-pong line buffer between frame memory and the VGA timing module (define SAVEMOD_OVERRUN_EN for overrun abort + sticky oErr)
module vga_linebuf_savemod #(
  parameter logic [9:0]  XSIZE     = 10'd320,
  parameter logic [9:0]  YSIZE     = 10'd240,
  parameter logic [16:0] BASE_ADDR = 17'd0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [10:0] iTag,
  input  logic        iEn,
  output logic [15:0] oData,
  output logic        oReq,
  output logic [16:0] oAddr,
  input  logic        iAck,
  input  logic [15:0] iMData,
  output logic        oErr
);
  localparam int AW = $clog2(XSIZE);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  logic [0:0]  state;
  logic        dsel;
  logic [9:0]  line;
  logic [9:0]  wc;
  logic [9:0]  rp;
  logic [15:0] bank [0:1][0:XSIZE-1];
  logic        tagValid;
  logic        lastAck;
  logic        startFill;
  logic [16:0] fillAddr;
  assign tagValid = iTag[10] && (iTag[9:0] < YSIZE);
  assign lastAck  = (state == FILL) && iAck && (wc == XSIZE - 10'd1);
  assign fillAddr = BASE_ADDR + 17'(line) * 17'(XSIZE) + 17'(wc);
  assign oReq     = state == FILL;
  assign oAddr    = oReq ? fillAddr : 17'd0;
`ifdef SAVEMOD_OVERRUN_EN
  logic overrun;
  logic errReg;
  // a strobe mid-fill abandons the current line and restarts with the new one
  assign overrun   = tagValid && (state == FILL) && !lastAck;
  assign startFill = tagValid;
  assign oErr      = errReg;
  // sticky overrun flag, cleared only by reset
  always_ff @(posedge CLOCK) begin
    if (RESET) errReg <= 1'b0;
    else if (overrun) errReg <= 1'b1;
  end
`else
  // mid-fill strobes are dropped; only an idle FSM or the final ack lets a new line start
  assign startFill = tagValid && ((state == IDLE) || lastAck);
  assign oErr      = 1'b0;
`endif
  // fill FSM: swap banks and latch the line on a start, count acked words to the end of the line
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      dsel  <= 1'b0;
      line  <= 10'd0;
      wc    <= 10'd0;
    end else if (startFill) begin
      state <= FILL;
      dsel  <= ~dsel;
      line  <= iTag[9:0];
      wc    <= 10'd0;
    end else if (lastAck) begin
      state <= IDLE;
    end else if ((state == FILL) && iAck) begin
      wc <= wc + 10'd1;
    end
  end
  // fill-bank write; acks arriving during reset are discarded
  always_ff @(posedge CLOCK) begin
    if (!RESET && (state == FILL) && iAck) bank[~dsel][wc[AW-1:0]] <= iMData;
  end
  // display side: one-cycle read of the display bank, pointer saturates at the last word
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      oData <= 16'd0;
      rp    <= 10'd0;
    end else begin
      oData <= iEn ? bank[dsel][rp[AW-1:0]] : 16'd0;
      rp    <= (startFill || !iEn) ? 10'd0 : (rp == XSIZE - 10'd1) ? rp : rp + 10'd1;
    end
  end
endmodule

// File: tb/tb_vga_linebuf_savemod.sv
// tb_vga_linebuf_savemod: directed table-driven bench for the ping-pong line buffer
module tb_vga_linebuf_savemod;
  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [10:0] iTag;
  logic        iEn;
  logic [15:0] oData;
  logic        oReq;
  logic [16:0] oAddr;
  logic        iAck;
  logic [15:0] iMData;
  logic        oErr;
  int          checks = 0;
  int          errors = 0;
  logic        expDsel = 1'b0;

  typedef struct {
    logic [9:0]  lineNo;
    int          ackPeriod;
    logic [16:0] firstAddr;
    bit          starts;
  } vec_t;
  vec_t vecs [5];

  vga_linebuf_savemod dut (
    .CLOCK(CLOCK), .RESET(RESET), .iTag(iTag), .iEn(iEn), .oData(oData), .oReq(oReq),
    .oAddr(oAddr), .iAck(iAck), .iMData(iMData), .oErr(oErr)
  );

  always #5 CLOCK = ~CLOCK;
  assign iMData = oAddr[15:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic strobe(input logic [9:0] n);
    iTag = {1'b1, n};
    step();
    iTag = {1'b0, n};
  endtask

  task automatic runVec(input vec_t v);
    int cnt = 0;
    int cyc = 0;
    strobe(v.lineNo);
    if (v.starts) begin
      expDsel = ~expDsel;
      chk("swap", {63'd0, dut.dsel}, {63'd0, expDsel});
      while (cnt < 320 && cyc < 2000) begin
        chk("fill_req", {63'd0, oReq}, 64'd1);
        chk("fill_addr", {47'd0, oAddr}, {47'd0, v.firstAddr} + 64'(cnt));
        iAck = (cyc % v.ackPeriod) == 0;
        step();
        if (iAck) cnt++;
        cyc++;
      end
      iAck = 1'b0;
      chk("fill_words", 64'(cnt), 64'd320);
      chk("fill_cycles_in_budget", {63'd0, cyc <= 320 * v.ackPeriod}, 64'd1);
      chk("req_drop", {63'd0, oReq}, 64'd0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk("ignored_req", {63'd0, oReq}, 64'd0);
        chk("ignored_addr", {47'd0, oAddr}, 64'd0);
        step();
      end
      chk("ignored_dsel", {63'd0, dut.dsel}, {63'd0, expDsel});
    end
  endtask

  task automatic displayCheck(input int base);
    iEn = 1'b1;
    for (int k = 1; k <= 322; k++) begin
      step();
      chk("disp_data", {48'd0, oData}, 64'(base + ((k - 1) > 319 ? 319 : (k - 1))));
    end
    iEn = 1'b0;
    step();
    chk("disp_idle_zero", {48'd0, oData}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{lineNo: 10'd5,    ackPeriod: 1, firstAddr: 17'd1600,  starts: 1'b1};
    vecs[1] = '{lineNo: 10'd0,    ackPeriod: 2, firstAddr: 17'd0,     starts: 1'b1};
    vecs[2] = '{lineNo: 10'd240,  ackPeriod: 1, firstAddr: 17'd0,     starts: 1'b0};
    vecs[3] = '{lineNo: 10'd239,  ackPeriod: 1, firstAddr: 17'd76480, starts: 1'b1};
    vecs[4] = '{lineNo: 10'd1023, ackPeriod: 1, firstAddr: 17'd0,     starts: 1'b0};
    RESET = 1'b1;
    iTag  = 11'd0;
    iEn   = 1'b1;
    iAck  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs", {29'd0, oData, oReq, oAddr, oErr}, 64'd0);
    end
    RESET = 1'b0;
    iEn = 1'b0;
    #1;
    chk("release_outputs", {29'd0, oData, oReq, oAddr, oErr}, 64'd0);
    step();
    chk("post_release_outputs", {29'd0, oData, oReq, oAddr, oErr}, 64'd0);
    chk("reset_dsel", {63'd0, dut.dsel}, 64'd0);
    for (int i = 0; i < 5; i++) runVec(vecs[i]);
    runVec(vecs[0]);
    strobe(10'd6);
    expDsel = ~expDsel;
    chk("line6_addr", {47'd0, oAddr}, 64'd1920);
    displayCheck(1600);
    iAck = 1'b1;
    for (int i = 0; i < 400 && oReq; i++) step();
    iAck = 1'b0;
    chk("line6_done", {63'd0, oReq}, 64'd0);
    strobe(10'd7);
    expDsel = ~expDsel;
    iAck = 1'b1;
    for (int i = 0; i < 319; i++) begin
      chk("line7_addr", {47'd0, oAddr}, 64'(2240 + i));
      step();
    end
    chk("line7_last_addr", {47'd0, oAddr}, 64'd2559);
    iTag = {1'b1, 10'd8};
    step();
    iTag = {1'b0, 10'd8};
    iAck = 1'b0;
    expDsel = ~expDsel;
    chk("coincident_req", {63'd0, oReq}, 64'd1);
    chk("coincident_addr", {47'd0, oAddr}, 64'd2560);
    chk("coincident_err", {63'd0, oErr}, 64'd0);
    chk("coincident_dsel", {63'd0, dut.dsel}, {63'd0, expDsel});
    displayCheck(2240);
    iAck = 1'b1;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    iAck = 1'b0;
    expDsel = 1'b0;
    chk("reset_in_fill_req", {63'd0, oReq}, 64'd0);
    chk("reset_in_fill_addr", {47'd0, oAddr}, 64'd0);
    chk("reset_in_fill_dsel", {63'd0, dut.dsel}, 64'd0);
    strobe(10'd3);
    expDsel = ~expDsel;
    iAck = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("line3_addr", {47'd0, oAddr}, 64'(960 + i));
      step();
    end
    iAck = 1'b0;
    strobe(10'd4);
`ifdef SAVEMOD_OVERRUN_EN
    expDsel = ~expDsel;
    chk("overrun_addr", {47'd0, oAddr}, 64'd1280);
    chk("overrun_err", {63'd0, oErr}, 64'd1);
    chk("overrun_dsel", {63'd0, dut.dsel}, {63'd0, expDsel});
    step();
    chk("overrun_err_sticky", {63'd0, oErr}, 64'd1);
`else
    chk("overrun_ignored_addr", {47'd0, oAddr}, 64'd1060);
    chk("overrun_ignored_err", {63'd0, oErr}, 64'd0);
    chk("overrun_ignored_dsel", {63'd0, dut.dsel}, {63'd0, expDsel});
`endif
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("final_reset_err", {63'd0, oErr}, 64'd0);
    chk("final_reset_req", {63'd0, oReq}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
